// File: rtl/pe_mac_sequencer.sv
// Job sequencer for the 49-lane FP16 MAC array and its adder tree: clear, feed N beats, drain, present result.
// Optional FEED stall counter enabled by defining PE_MAC_SEQ_STALL_CNT_EN.
module pe_mac_sequencer #(
    parameter int MAC_LAT  = 1,
    parameter int TREE_LAT = 6,
    parameter int STEP_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [STEP_W-1:0] num_steps,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mac_clr,
    output logic              mac_en,
    input  logic [15:0]       tree_sum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       stall_cnt
);

    localparam int DRAIN_CYC = MAC_LAT + TREE_LAT;
    localparam int DRAIN_W   = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYC - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, OUT} state_t;

    state_t              state, state_nx;
    logic [STEP_W-1:0]   steps_lat;
    logic [STEP_W-1:0]   step_cnt;
    logic [DRAIN_W-1:0]  drain_cnt;
    logic [15:0]         out_data_q;
    logic                err_q;
    logic                job_go;
    logic                last_beat;

    assign job_go    = (state == IDLE) && start && (num_steps != '0);
    assign last_beat = in_valid && ((step_cnt + STEP_W'(1)) == steps_lat);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            steps_lat  <= '0;
            step_cnt   <= '0;
            drain_cnt  <= '0;
            out_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state <= state_nx;
            err_q <= (state == IDLE) && start && (num_steps == '0);
            if (job_go)
                steps_lat <= num_steps;
            if (state == CLEAR)
                step_cnt <= '0;
            else if (state == FEED && in_valid)
                step_cnt <= step_cnt + STEP_W'(1);
            // Down-counter idles at its load value so DRAIN always starts full.
            if (state != DRAIN)
                drain_cnt <= DRAIN_LOAD;
            else if (drain_cnt != '0)
                drain_cnt <= drain_cnt - DRAIN_W'(1);
            if (state == DRAIN && drain_cnt == '0)
                out_data_q <= tree_sum;
        end
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        mac_en   = 1'b0;
        mac_clr  = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (job_go)
                    state_nx = CLEAR;
            end
            CLEAR: begin
                mac_clr  = 1'b1;
                state_nx = FEED;
            end
            FEED: begin
                in_ready = 1'b1;
                mac_en   = in_valid;
                if (last_beat)
                    state_nx = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt == '0)
                    state_nx = OUT;
            end
            OUT: begin
                done = out_ready;
                if (out_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign out_valid = (state == OUT);
    assign out_data  = out_data_q;
    assign busy      = (state != IDLE);
    assign err       = err_q;

`ifdef PE_MAC_SEQ_STALL_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst)
            stall_cnt_q <= '0;
        else if (job_go)
            stall_cnt_q <= '0;
        else if (state == FEED && !in_valid)
            stall_cnt_q <= sat_inc(stall_cnt_q);
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pe_mac_sequencer.sv
// Scoreboard bench for pe_mac_sequencer: jobs, stalls, zero-length start, OUT backpressure, mid-job reset.
module tb_pe_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  num_steps;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mac_clr;
    logic        mac_en;
    logic [15:0] tree_sum;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;
    int n_clr = 0, n_en = 0, n_done = 0, n_err = 0, n_busy = 0;
    bit tog = 1'b0;
    int feed_idx = 0;
    logic [15:0] exp_q[$];

    pe_mac_sequencer #(.MAC_LAT(1), .TREE_LAT(6), .STEP_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .num_steps(num_steps),
        .in_valid(in_valid), .in_ready(in_ready), .mac_clr(mac_clr), .mac_en(mac_en),
        .tree_sum(tree_sum), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .done(done), .err(err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Operand source: constant beats, or 1,0,1,0... starting with the first FEED cycle.
    always @(posedge clk) begin
        #1;
        if (in_ready) begin
            in_valid = tog ? (feed_idx % 2 == 0) : 1'b1;
            feed_idx++;
        end else begin
            in_valid = 1'b0;
            feed_idx = 0;
        end
    end

    always @(negedge clk) begin
        n_clr  += int'(mac_clr);
        n_en   += int'(mac_en);
        n_done += int'(done);
        n_err  += int'(err);
        n_busy += int'(busy);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_job(input logic [7:0] n, input bit tg, input logic [15:0] sum,
                           input int hold, output int lat, output int d_clr, output int d_en);
        int c0, e0, dn0;
        @(posedge clk); #1;
        start = 1'b1; num_steps = n; tree_sum = sum; tog = tg;
        exp_q.push_back(sum);
        c0 = n_clr; e0 = n_en; dn0 = n_done;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!out_valid && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("out_valid_timeout", out_valid, 1'b1);
        // Downstream stalls; result must hold and a new start must be ignored.
        if (hold > 0) begin
            tree_sum = ~sum;
            start = 1'b1; num_steps = 8'd2;
        end
        for (int i = 0; i < hold; i++) begin
            check_eq("hold_valid", out_valid, 1'b1);
            check_eq("hold_data", out_data, sum);
            check_eq("hold_done", done, 1'b0);
            @(posedge clk); #1;
        end
        start = 1'b0;
        out_ready = 1'b1;
        #1;
        check_eq("done_on_handshake", done, 1'b1);
        if (out_valid && exp_q.size() > 0)
            check_eq("out_data", out_data, exp_q.pop_front());
        else
            check_eq("sb_output_present", 1'b0, 1'b1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("post_out_valid", out_valid, 1'b0);
        check_eq("post_busy", busy, 1'b0);
        check_eq("done_count", n_done - dn0, 1);
        d_clr = n_clr - c0;
        d_en  = n_en - e0;
    endtask

    initial begin
        int lat, d_clr, d_en, e0, c0, b0, r0, dn0, k;
        logic [15:0] exp_stall;
        rst = 1'b0; start = 1'b0; num_steps = '0; tree_sum = '0; out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", in_ready, 1'b0);
        check_eq("rst_mac_clr", mac_clr, 1'b0);
        check_eq("rst_mac_en", mac_en, 1'b0);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_err", err, 1'b0);
        check_eq("rst_out_data", out_data, 16'h0);
        check_eq("rst_stall_cnt", stall_cnt, 16'h0);
        rst = 1'b1;

        // N=3, constant beats: 1 CLEAR + 3 FEED + 7 DRAIN edges.
        run_job(8'd3, 1'b0, 16'h4200, 0, lat, d_clr, d_en);
        check_eq("j1_latency", lat, 11);
        check_eq("j1_clr_cycles", d_clr, 1);
        check_eq("j1_en_cycles", d_en, 3);

        // N=4, alternating beats: 7 FEED cycles, 3 stalls.
        run_job(8'd4, 1'b1, 16'h3C00, 0, lat, d_clr, d_en);
        check_eq("j2_latency", lat, 15);
        check_eq("j2_en_cycles", d_en, 4);
`ifdef PE_MAC_SEQ_STALL_CNT_EN
        exp_stall = 16'd3;
`else
        exp_stall = 16'd0;
`endif
        check_eq("j2_stall_cnt", stall_cnt, exp_stall);

        // Zero-length job.
        c0 = n_clr; b0 = n_busy; r0 = n_err;
        @(posedge clk); #1;
        start = 1'b1; num_steps = 8'd0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("zero_err_pulses", n_err - r0, 1);
        check_eq("zero_busy", n_busy - b0, 0);
        check_eq("zero_clr", n_clr - c0, 0);

        // Backpressure in OUT for 5 cycles with start asserted.
        run_job(8'd2, 1'b0, 16'hC500, 5, lat, d_clr, d_en);
        check_eq("j3_latency", lat, 10);
        check_eq("j3_clr_cycles", d_clr, 1);
        check_eq("j3_en_cycles", d_en, 2);

        // Reset during FEED after 2 of 5 beats.
        @(posedge clk); #1;
        start = 1'b1; num_steps = 8'd5; tog = 1'b0; tree_sum = 16'hFFFF;
        e0 = n_en; dn0 = n_done;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while ((n_en - e0) < 2 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_eq("rst_job_two_beats", (n_en - e0) >= 2, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("mid_rst_in_ready", in_ready, 1'b0);
        check_eq("mid_rst_mac_en", mac_en, 1'b0);
        check_eq("mid_rst_mac_clr", mac_clr, 1'b0);
        check_eq("mid_rst_out_valid", out_valid, 1'b0);
        check_eq("mid_rst_busy", busy, 1'b0);
        check_eq("mid_rst_done", done, 1'b0);
        check_eq("mid_rst_err", err, 1'b0);
        check_eq("mid_rst_out_data", out_data, 16'h0);
        check_eq("mid_rst_stall_cnt", stall_cnt, 16'h0);
        rst = 1'b1;
        check_eq("mid_rst_no_done", n_done - dn0, 0);

        // Fresh job after the abort.
        run_job(8'd5, 1'b0, 16'h1234, 0, lat, d_clr, d_en);
        check_eq("j4_latency", lat, 13);
        check_eq("j4_en_cycles", d_en, 5);
        check_eq("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
